// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared constants, FSM state type and helpers for the 4-master bus arbiter
package bus_arbiter_pkg;
  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W = 2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  typedef enum logic {ARB_ST_IDLE = 1'b0, ARB_ST_GRANT = 1'b1} arb_st_t;
  function automatic logic [BUS_MASTER_CH-1:0] onehot(input logic [BUS_OWNER_W-1:0] idx);
    return BUS_MASTER_CH'(1) << idx;
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: active-low request/grant bundle between masters and the arbiter
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;
  logic m0_req_, m1_req_, m2_req_, m3_req_;
  logic bus_as_;
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [BUS_OWNER_W-1:0] bus_owner;
  logic grant_vld;
  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, bus_as_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, grant_vld
  );
  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, bus_as_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, grant_vld
  );
endinterface

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational round-robin pick, first requester after i_last wrapping 3->0
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] i_req,
  input  logic [BUS_OWNER_W-1:0]   i_last,
  output logic [BUS_OWNER_W-1:0]   o_pick,
  output logic                     o_pick_vld
);
  // scan from farthest to nearest so the nearest requester overwrites
  always_comb begin
    o_pick = i_last;
    for (int k = BUS_MASTER_CH; k >= 1; k--)
      if (i_req[i_last + BUS_OWNER_W'(k)]) o_pick = i_last + BUS_OWNER_W'(k);
  end
  assign o_pick_vld = |i_req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with hold-timer preemption that never preempts mid-transfer
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W = 8
)(
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bus
);
  arb_st_t r_state;
  logic [BUS_OWNER_W-1:0] r_owner, r_last;
  logic [HOLD_W-1:0] r_cnt;
  logic [BUS_MASTER_CH-1:0] r_grnt_;
  logic r_vld;
  logic [BUS_MASTER_CH-1:0] w_req;
  logic [BUS_OWNER_W-1:0] w_pick;
  logic w_pick_vld, w_own_req, w_others, w_timeout, w_hand, w_idle;
  assign w_req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  bus_rr_pick u_pick (
    .i_req(w_req),
    .i_last(r_state == ARB_ST_GRANT ? r_owner : r_last),
    .o_pick(w_pick),
    .o_pick_vld(w_pick_vld)
  );
  assign w_own_req = w_req[r_owner];
  assign w_others = |(w_req & ~onehot(r_owner));
  assign w_timeout = r_cnt >= HOLD_W'(MAX_HOLD - 1);
  // release wins over timeout; timeout waits for the bus to go idle
  assign w_hand = (r_state == ARB_ST_GRANT) && w_others &&
                  (!w_own_req || (w_timeout && bus.bus_as_ == DISABLE_));
  assign w_idle = (r_state == ARB_ST_GRANT) && !w_own_req && !w_others;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_ST_IDLE;
      r_grnt_ <= '1;
      r_vld <= 1'b0;
      r_owner <= BUS_OWNER_MASTER_0;
      r_last <= BUS_OWNER_MASTER_3;
      r_cnt <= '0;
    end else if (r_state == ARB_ST_IDLE) begin
      if (w_pick_vld) begin
        r_state <= ARB_ST_GRANT;
        r_owner <= w_pick;
        r_grnt_ <= ~onehot(w_pick);
        r_vld <= 1'b1;
        r_cnt <= '0;
      end
    end else if (w_hand) begin
      r_last <= r_owner;
      r_owner <= w_pick;
      r_grnt_ <= ~onehot(w_pick);
      r_cnt <= '0;
    end else if (w_idle) begin
      r_state <= ARB_ST_IDLE;
      r_last <= r_owner;
      r_grnt_ <= '1;
      r_vld <= 1'b0;
    end else if (r_cnt != HOLD_W'(MAX_HOLD)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_} = r_grnt_;
  assign bus.bus_owner = r_owner;
  assign bus.grant_vld = r_vld;
endmodule
